// File: rtl/cdb_arbiter_if.sv
// Common data bus result type and the producer/arbiter bundle used by cdb_arbiter.
// The package travels with the interface so every user of the bundle sees one cdb_t.
package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic        exc;
        logic [5:0]  rob_idx;
        logic [6:0]  preg;
        logic [31:0] data;
    } cdb_t;
endpackage

interface cdb_arbiter_if #(
    parameter int NUM_SRC = 5
);
    import cdb_pkg::*;

    logic [NUM_SRC-1:0] src_valid;
    cdb_t [NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0] src_ready;
    cdb_t               cdb_out;

    modport master (output src_valid, src_data, input src_ready, cdb_out);
    modport slave  (input src_valid, src_data, output src_ready, cdb_out);
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-source result FIFOs feeding one registered CDB broadcast per cycle.
// Define CDB_ARB_RR_EN for round-robin arbitration; otherwise lowest index wins.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int DEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] not_empty;
    cdb_t [NUM_SRC-1:0] head_ent;
    logic               grant_valid;
    logic [IDX_W-1:0]   grant_idx;
    cdb_t               cdb_q;

    // Ready comes from the registered count only, so a full FIFO being popped still stalls.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [PTR_W-1:0] head_r;
        logic [PTR_W-1:0] tail_r;
        logic [CNT_W-1:0] cnt_r;
        cdb_t             mem_r [DEPTH];
        logic             do_push;
        logic             do_pop;

        assign ready[i]     = (cnt_r < CNT_W'(DEPTH));
        assign not_empty[i] = (cnt_r != '0);
        assign head_ent[i]  = mem_r[head_r];
        assign do_push      = bus.src_valid[i] & ready[i] & ~flush;
        assign do_pop       = grant_valid & (grant_idx == IDX_W'(i));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                head_r <= '0;
                tail_r <= '0;
                cnt_r  <= '0;
            end else if (flush) begin
                head_r <= '0;
                tail_r <= '0;
                cnt_r  <= '0;
            end else begin
                if (do_push) tail_r <= tail_r + 1'b1;
                if (do_pop)  head_r <= head_r + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   cnt_r <= cnt_r + 1'b1;
                    2'b01:   cnt_r <= cnt_r - 1'b1;
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (do_push) mem_r[tail_r] <= bus.src_data[i];
        end
    end

    assign bus.src_ready = ready;

`ifdef CDB_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // Pointer remembers the last winner; it only moves when something is actually granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           rr_ptr <= IDX_W'(NUM_SRC - 1);
        else if (grant_valid) rr_ptr <= grant_idx;
    end

    always_comb begin
        logic [IDX_W-1:0] cand_idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand_idx = IDX_W'((int'(rr_ptr) + 1 + k) % NUM_SRC);
            if (!grant_valid && not_empty[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        if (flush) grant_valid = 1'b0;
    end
`else
    // Descending scan so the lowest non-empty index is the last, and winning, assignment.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (not_empty[k]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
        if (flush) grant_valid = 1'b0;
    end
`endif

    // Idle cycles only drop valid; payload fields keep their last broadcast value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q <= '0;
        end else if (grant_valid) begin
            cdb_q       <= head_ent[grant_idx];
            cdb_q.valid <= 1'b1;
        end else begin
            cdb_q.valid <= 1'b0;
        end
    end

    assign bus.cdb_out = cdb_q;

endmodule
